// File: rtl/ifetch_byte_sequencer.sv
// ifetch_byte_sequencer: IF-stage fetch controller that reads four bytes
// (pc..pc+3) from a byte-wide instruction memory and assembles a big-endian
// 32-bit instruction. It also reports misaligned/out-of-range PCs and memory
// timeouts.
//
// Ports:
//   CLK, Reset        rising-edge clock, synchronous active-high reset
//   fetch_req, pc     fetch request and its byte address (sampled on accept)
//   InsMemRW          memory enable; a request is accepted only while high
//   flush             abort an in-progress fetch, block acceptance in idle
//   fetch_busy        high while reading bytes and during the report cycle
//   instruction       last successfully fetched instruction (held)
//   ins_valid         one-cycle pulse: instruction just updated
//   addr_err          one-cycle pulse: pc misaligned or out of range
//   timeout_err       one-cycle pulse: memory did not ack in time
//   mem_addr, mem_re  byte read address and request (held until mem_ack)
//   mem_rdata, mem_ack  read byte and its completion strobe
module ifetch_byte_sequencer #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        InsMemRW,
    input  logic        flush,
    output logic        fetch_busy,
    output logic [31:0] instruction,
    output logic        ins_valid,
    output logic        addr_err,
    output logic        timeout_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] MAX_PC    = ADDR_W'(MEM_BYTES - 4);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BYTE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        E_NONE    = 2'd0,
        E_ADDR    = 2'd1,
        E_TIMEOUT = 2'd2
    } err_t;

    state_t              state, state_next;
    err_t                err_next;
    logic [1:0]          idx, idx_next;
    logic [TCNT_W-1:0]   tcnt, tcnt_next;
    logic [ADDR_W-1:0]   base, base_next;
    logic [31:0]         shadow, shadow_next;
    logic                load_ins;

    // Next-state, byte capture and report selection.
    always_comb begin
        state_next  = state;
        err_next    = E_NONE;
        idx_next    = idx;
        tcnt_next   = tcnt;
        base_next   = base;
        shadow_next = shadow;
        load_ins    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (fetch_req && InsMemRW && !flush) begin
                    base_next = pc;
                    idx_next  = 2'd0;
                    tcnt_next = '0;
                    if ((pc[1:0] != 2'b00) || (pc > MAX_PC)) begin
                        state_next = S_DONE;
                        err_next   = E_ADDR;
                    end else begin
                        state_next = S_BYTE;
                    end
                end
            end

            S_BYTE: begin
                if (flush) begin
                    // flush outranks a simultaneous final ack
                    state_next = S_IDLE;
                    idx_next   = 2'd0;
                    tcnt_next  = '0;
                end else if (mem_ack) begin
                    unique case (idx)
                        2'd0: shadow_next[31:24] = mem_rdata;
                        2'd1: shadow_next[23:16] = mem_rdata;
                        2'd2: shadow_next[15:8]  = mem_rdata;
                        2'd3: shadow_next[7:0]   = mem_rdata;
                    endcase
                    tcnt_next = '0;
                    if (idx == 2'd3) begin
                        load_ins   = 1'b1;
                        state_next = S_DONE;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = idx + 2'd1;
                    end
                end else if (tcnt == TCNT_LAST) begin
                    // an ack in this same cycle would have taken the branch above
                    state_next = S_DONE;
                    err_next   = E_TIMEOUT;
                    idx_next   = 2'd0;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + TCNT_W'(1);
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; outputs are registered from the next-state decode so
    // they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_IDLE;
            idx         <= 2'd0;
            tcnt        <= '0;
            base        <= '0;
            shadow      <= '0;
            instruction <= '0;
            fetch_busy  <= 1'b0;
            mem_re      <= 1'b0;
            mem_addr    <= '0;
            ins_valid   <= 1'b0;
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            tcnt   <= tcnt_next;
            base   <= base_next;
            shadow <= shadow_next;
            if (load_ins) begin
                instruction <= shadow_next;
            end
            fetch_busy  <= (state_next != S_IDLE);
            mem_re      <= (state_next == S_BYTE);
            mem_addr    <= (state_next == S_BYTE) ? (base_next + ADDR_W'(idx_next)) : '0;
            ins_valid   <= (state_next == S_DONE) && (err_next == E_NONE);
            addr_err    <= (state_next == S_DONE) && (err_next == E_ADDR);
            timeout_err <= (state_next == S_DONE) && (err_next == E_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_ifetch_byte_sequencer.sv
// Testbench for ifetch_byte_sequencer: directed fetch table, hand-written
// flush/reset/gating sequences, then randomized traffic against a
// transaction-level reference model.
module tb_ifetch_byte_sequencer;

    localparam int unsigned MEM_BYTES = 128;
    localparam int unsigned TIMEOUT   = 8;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        fetch_req;
    logic [31:0] pc;
    logic        InsMemRW;
    logic        flush;
    logic        fetch_busy;
    logic [31:0] instruction;
    logic        ins_valid;
    logic        addr_err;
    logic        timeout_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instr = '0;
    logic [7:0]  mem [MEM_BYTES];

    typedef struct {
        string       name;
        logic [31:0] pc;
        int          dly;       // idle cycles before each ack
        logic [31:0] word;
        int          exp_kind;  // 1 ins_valid, 2 addr_err, 3 timeout_err
        int          exp_cyc;   // cycle of the pulse, request in cycle 0
        int          exp_re;    // number of cycles with mem_re high
        bit          upd;       // instruction becomes word
    } vec_t;

    vec_t vecs[10];

    always #5 CLK = ~CLK;

    ifetch_byte_sequencer #(
        .MEM_BYTES (MEM_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .InsMemRW    (InsMemRW),
        .flush       (flush),
        .fetch_busy  (fetch_busy),
        .instruction (instruction),
        .ins_valid   (ins_valid),
        .addr_err    (addr_err),
        .timeout_err (timeout_err),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int pulses();
        return int'(ins_valid) + int'(addr_err) + int'(timeout_err);
    endfunction

    // One fetch from the table: acts as the memory and records what it saw.
    task automatic run_vec(input vec_t v);
        int k        = 0;
        int waited   = 0;
        int re_n     = 0;
        int npulse   = 0;
        int kind     = 0;
        int pcyc     = 0;
        int addr_bad = 0;
        int busy_bad = 0;
        if (v.upd) begin
            for (int b = 0; b < 4; b++) begin
                mem[v.pc[6:0] + 7'(b)] = v.word[31 - 8*b -: 8];
            end
        end
        fetch_req = 1'b1;
        InsMemRW  = 1'b1;
        pc        = v.pc;
        mem_ack   = 1'b0;
        for (int cyc = 1; cyc <= v.exp_cyc + 3; cyc++) begin
            tick();
            fetch_req = 1'b0;
            InsMemRW  = 1'b0;   // dropping the enable mid-fetch must not abort
            if (fetch_busy !== (cyc <= v.exp_cyc)) busy_bad++;
            if (pulses() != 0) begin
                npulse += pulses();
                pcyc = cyc;
                kind = ins_valid ? 1 : (addr_err ? 2 : 3);
            end
            if (mem_re) begin
                re_n++;
                if (mem_addr !== v.pc + 32'(k)) addr_bad++;
                if (waited >= v.dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[6:0]];
                    k++;
                    waited = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    waited++;
                end
            end else begin
                mem_ack   = 1'($urandom);   // must be ignored while mem_re is low
                mem_rdata = 8'($urandom);
            end
        end
        mem_ack = 1'b0;
        if (v.upd) exp_instr = v.word;
        chk({v.name, " kind"},     32'(kind),     32'(v.exp_kind));
        chk({v.name, " cycle"},    32'(pcyc),     32'(v.exp_cyc));
        chk({v.name, " npulse"},   32'(npulse),   32'd1);
        chk({v.name, " re_count"}, 32'(re_n),     32'(v.exp_re));
        chk({v.name, " addr_bad"}, 32'(addr_bad), 32'd0);
        chk({v.name, " busy_bad"}, 32'(busy_bad), 32'd0);
        chk({v.name, " instr"},    instruction,   exp_instr);
    endtask

    // Randomized traffic checked against a transaction-level model.
    task automatic run_random(input int n);
        int              m_phase = 0;   // 0 idle, 1 reading bytes, 2 reporting
        int              m_pos   = 0;
        int              m_wait  = 0;
        int              m_kind  = 0;
        logic [31:0]     m_base  = '0;
        logic [31:0]     m_acc   = '0;
        logic [31:0]     m_instr = exp_instr;
        bit              stall   = 1'b0;
        bit              legal;
        longint unsigned lp;
        int              r;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rnd busy",    32'(fetch_busy),  32'(m_phase != 0));
            chk("rnd mem_re",  32'(mem_re),      32'(m_phase == 1));
            if (m_phase == 1) chk("rnd mem_addr", mem_addr, m_base + 32'(m_pos));
            chk("rnd valid",   32'(ins_valid),   32'(m_phase == 2 && m_kind == 1));
            chk("rnd addr_err", 32'(addr_err),   32'(m_phase == 2 && m_kind == 2));
            chk("rnd timeout", 32'(timeout_err), 32'(m_phase == 2 && m_kind == 3));
            chk("rnd instr",   instruction,      m_instr);

            Reset     = ($urandom_range(0, 299) == 0);
            fetch_req = ($urandom_range(0, 2) != 0);
            InsMemRW  = ($urandom_range(0, 5) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 7)       pc = 32'(4 * $urandom_range(0, 31));
            else if (r == 7) pc = 32'($urandom_range(0, 130));
            else if (r == 8) pc = 32'(MEM_BYTES - 4 + 4 * $urandom_range(0, 2));
            else             pc = $urandom;
            if ($urandom_range(0, 49) == 0) stall = !stall;
            mem_ack   = stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
            mem_rdata = 8'($urandom);

            if (Reset) begin
                m_phase = 0;
                m_instr = '0;
            end else begin
                case (m_phase)
                    0: if (fetch_req && InsMemRW && !flush) begin
                        lp     = 64'(pc);
                        legal  = (lp % 4 == 0) && (lp + 4 <= 64'(MEM_BYTES));
                        m_base = pc;
                        if (legal) begin
                            m_phase = 1;
                            m_pos   = 0;
                            m_wait  = 0;
                            m_acc   = '0;
                        end else begin
                            m_phase = 2;
                            m_kind  = 2;
                        end
                    end
                    1: if (flush) begin
                        m_phase = 0;
                    end else if (mem_ack) begin
                        m_acc  = m_acc | (32'(mem_rdata) << (8 * (3 - m_pos)));
                        m_pos++;
                        m_wait = 0;
                        if (m_pos == 4) begin
                            m_instr = m_acc;
                            m_phase = 2;
                            m_kind  = 1;
                        end
                    end else begin
                        m_wait++;
                        if (m_wait >= int'(TIMEOUT)) begin
                            m_phase = 2;
                            m_kind  = 3;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
        Reset     = 1'b0;
        fetch_req = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the test ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int          np;
        logic [31:0] word;
        vec_t        after_flush;

        vecs[0] = '{"zero_wait",  32'h0000_0000, 0,   32'h8C01_0004, 1, 5,  4,  1'b1};
        vecs[1] = '{"wait2",      32'h0000_0008, 2,   32'h1234_5678, 1, 13, 12, 1'b1};
        vecs[2] = '{"misaligned", 32'h0000_0006, 0,   32'h0,         2, 1,  0,  1'b0};
        vecs[3] = '{"range128",   32'h0000_0080, 0,   32'h0,         2, 1,  0,  1'b0};
        vecs[4] = '{"last_legal", 32'h0000_007C, 1,   32'hCAFE_F00D, 1, 9,  8,  1'b1};
        vecs[5] = '{"range132",   32'h0000_0084, 0,   32'h0,         2, 1,  0,  1'b0};
        vecs[6] = '{"wrap_pc",    32'hFFFF_FFFC, 0,   32'h0,         2, 1,  0,  1'b0};
        vecs[7] = '{"timeout",    32'h0000_0010, 100, 32'h0,         3, 9,  8,  1'b0};
        vecs[8] = '{"late_ack",   32'h0000_0014, 7,   32'hDEAD_BEEF, 1, 33, 32, 1'b1};
        vecs[9] = '{"wait3",      32'h0000_0040, 3,   32'h0BAD_C0DE, 1, 17, 16, 1'b1};
        after_flush = '{"after_flush", 32'h0000_0000, 0, 32'hA5A5_0F0F, 1, 5, 4, 1'b1};

        for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);

        Reset = 1'b1; fetch_req = 1'b0; pc = '0; InsMemRW = 1'b0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst busy",    32'(fetch_busy),  32'd0);
        chk("rst instr",   instruction,      32'd0);
        chk("rst valid",   32'(ins_valid),   32'd0);
        chk("rst addr",    32'(addr_err),    32'd0);
        chk("rst timeout", 32'(timeout_err), 32'd0);
        chk("rst mem_re",  32'(mem_re),      32'd0);
        chk("rst mem_addr", mem_addr,        32'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Flush after the second ack at pc=4, then a clean fetch at pc=0.
        fetch_req = 1'b1; InsMemRW = 1'b1; pc = 32'd4;
        tick(); fetch_req = 1'b0;
        chk("flushA re c1", 32'(mem_re), 32'd1);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick(); mem_ack = 1'b1; mem_rdata = 8'h22;
        tick();
        chk("flushA re c3", 32'(mem_re), 32'd1);
        chk("flushA addr c3", mem_addr, 32'd6);
        mem_ack = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        chk("flushA re drop", 32'(mem_re), 32'd0);
        chk("flushA busy", 32'(fetch_busy), 32'd0);
        np = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            np += pulses();
        end
        chk("flushA no pulse", 32'(np), 32'd0);
        chk("flushA instr", instruction, exp_instr);
        run_vec(after_flush);

        // Flush coinciding with the fourth ack must not update instruction.
        fetch_req = 1'b1; InsMemRW = 1'b1; pc = 32'd12;
        for (int c = 1; c <= 4; c++) begin
            tick(); fetch_req = 1'b0;
            mem_ack = 1'b1; mem_rdata = 8'h5A + 8'(c);
            if (c == 4) flush = 1'b1;
        end
        tick(); flush = 1'b0; mem_ack = 1'b0;
        chk("flushB valid", 32'(ins_valid), 32'd0);
        chk("flushB mem_re", 32'(mem_re), 32'd0);
        np = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            np += pulses();
        end
        chk("flushB no pulse", 32'(np), 32'd0);
        chk("flushB instr", instruction, exp_instr);

        // Request held high: DONE ignores it, next acceptance in cycle 6.
        word = {mem[0], mem[1], mem[2], mem[3]};
        fetch_req = 1'b1; InsMemRW = 1'b1; pc = 32'd0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            mem_ack = 1'b1; mem_rdata = mem[mem_addr[6:0]];
        end
        tick(); mem_ack = 1'b0;
        chk("b2b valid c5", 32'(ins_valid), 32'd1);
        chk("b2b instr c5", instruction, word);
        exp_instr = word;
        tick();
        chk("b2b re c6", 32'(mem_re), 32'd0);
        chk("b2b busy c6", 32'(fetch_busy), 32'd0);
        tick();
        chk("b2b re c7", 32'(mem_re), 32'd1);
        chk("b2b addr c7", mem_addr, 32'd0);
        fetch_req = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        chk("b2b flushed", 32'(fetch_busy), 32'd0);

        // Gating: no acceptance without InsMemRW or with flush.
        fetch_req = 1'b1; InsMemRW = 1'b0; pc = 32'd0;
        np = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            np += int'(mem_re) + int'(fetch_busy);
        end
        InsMemRW = 1'b1; flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            np += int'(mem_re) + int'(fetch_busy);
        end
        chk("gate no access", 32'(np), 32'd0);
        fetch_req = 1'b0; flush = 1'b0;
        tick();

        // Reset in the middle of a byte read.
        fetch_req = 1'b1; InsMemRW = 1'b1; pc = 32'd8; mem_ack = 1'b0;
        tick(); fetch_req = 1'b0;
        chk("rstmid re c1", 32'(mem_re), 32'd1);
        tick(); Reset = 1'b1;
        tick(); Reset = 1'b0;
        chk("rstmid busy",  32'(fetch_busy), 32'd0);
        chk("rstmid re",    32'(mem_re),     32'd0);
        chk("rstmid addr",  mem_addr,        32'd0);
        chk("rstmid instr", instruction,     32'd0);
        chk("rstmid pulse", 32'(pulses()),   32'd0);
        exp_instr = '0;
        np = 0;
        for (int c = 0; c < 12; c++) begin
            mem_ack = 1'($urandom);
            tick();
            np += pulses() + int'(mem_re);
        end
        mem_ack = 1'b0;
        chk("rstmid quiet", 32'(np), 32'd0);

        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_byte_sequencer.md
Name: ifetch_byte_sequencer

Overview:
- Fetch controller between the multicycle control unit and a byte-wide instruction memory.
- On request, issues four sequential byte reads at pc..pc+3 with a per-byte ack handshake and assembles a big-endian 32-bit instruction.
- Holds the last completed instruction and flags misaligned or out-of-range PCs and memory timeouts.
- Sits in the IF stage; the control unit waits on ins_valid before advancing to ID.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; legal PCs are 0..MEM_BYTES-4.
- TIMEOUT, 8, maximum consecutive un-acked cycles per byte read before abort (>=1).

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  control unit requests a fetch at pc.
- pc  in  32  byte address of instruction; sampled only on acceptance.
- InsMemRW  in  1  instruction-memory enable; a request is accepted only when high.
- flush  in  1  abort any in-progress fetch.
- fetch_busy  out  1  high in BYTE and DONE states.
- instruction  out  32  last successfully fetched instruction (held).
- ins_valid  out  1  one-cycle pulse: instruction just updated.
- addr_err  out  1  one-cycle pulse: pc misaligned or out of range.
- timeout_err  out  1  one-cycle pulse: memory failed to ack in time.
- mem_addr  out  32  byte address to memory.
- mem_re  out  1  byte read request, held until mem_ack.
- mem_rdata  in  8  read byte; valid in a cycle where mem_ack=1.
- mem_ack  in  1  memory completes current byte; sampled only while mem_re=1.

Behaviour:
- Reset (sync, active-high, priority over everything): state IDLE. All outputs 0: instruction, ins_valid, addr_err, timeout_err, mem_re, mem_addr, fetch_busy. Byte index, timeout counter and shadow register cleared. Reset mid-fetch abandons the fetch silently.
- States: IDLE, BYTE, DONE.
- IDLE:
  - Accepts a request when fetch_req & InsMemRW & !flush. On acceptance, latches pc into base.
  - If pc[1:0]!=0 or pc>MEM_BYTES-4: go to DONE with err=addr. No memory access occurs.
  - Otherwise: go to BYTE, idx=0.
- BYTE:
  - Outputs: mem_re=1, mem_addr=base+idx; mem_addr is stable while waiting.
  - On mem_ack: mem_rdata is written into shadow[31-8*idx -: 8], idx increments, timeout counter clears.
  - On ack with idx==3: instruction<=assembled word (same edge), then DONE with err=none.
  - Timeout counter increments each BYTE cycle without ack. When TIMEOUT consecutive cycles pass without ack: DONE with err=timeout; instruction unchanged.
  - An ack in the same cycle as the timeout limit wins.
- DONE (exactly one cycle):
  - Drives exactly one of ins_valid, addr_err or timeout_err per err.
  - mem_re=0. Requests are ignored. Next state IDLE.
- flush:
  - In BYTE: next state IDLE, mem_re drops next cycle, no pulses, instruction unchanged. flush wins over a simultaneous final ack.
  - In IDLE: blocks acceptance.
  - In DONE: no effect; the pulse still occurs.
- InsMemRW dropping mid-fetch does not abort.
- Latency with zero-wait memory (ack in same cycle as mem_re): request at cycle 0, mem_re in cycles 1-4, ins_valid in cycle 5. Earliest next acceptance is cycle 6.
- mem_ack while mem_re=0 is ignored.
- Address arithmetic is 32-bit; base+3 never wraps because the range is checked.

Test Plan:
- Zero-wait fetch: pc=0, bytes 8C,01,00,04 -> mem_addr 0,1,2,3 in cycles 1-4; instruction=0x8C010004 and ins_valid=1 in cycle 5; fetch_busy high cycles 1-5.
- Wait states: pc=8, each ack delayed 2 cycles, bytes 12,34,56,78 -> mem_addr held 2 extra cycles per byte; instruction=0x12345678; ins_valid at cycle 13; no timeout_err.
- Bad address: pc=6, then pc=128 (MEM_BYTES=128) -> addr_err pulse in cycle 1 each time; mem_re never asserts; instruction keeps prior value.
- Flush after second ack at pc=4 -> mem_re low next cycle; no ins_valid; instruction unchanged. A following fetch at pc=0 completes normally. flush coinciding with the 4th ack -> instruction not updated.
- Timeout: mem_ack held 0 with TIMEOUT=8 -> timeout_err pulses exactly once; instruction unchanged; IDLE after; an ack in the 8th waiting cycle completes the byte instead.
- Gating/reset: fetch_req=1 with InsMemRW=0 -> no mem_re. Reset asserted mid-BYTE -> all outputs 0 next cycle, instruction=0; no pulse afterwards.
